// File: rtl/aux_ran_harvester.sv
// Entropy harvester behind the auxRanSet latch array: synchronise, strobe-sample, XOR-fold, assemble words.
// Define AUXRAN_VN_DEBIAS_EN to insert a von Neumann debiaser between the fold and the shifter.
module aux_ran_harvester #(
    parameter int N_BLOCKS    = 12,
    parameter int WORD_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DIV  = 4,
    parameter int REP_LIMIT   = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enb,
    input  logic [N_BLOCKS-1:0] i_block_Qs,
    output logic                o_src_enb,
    output logic [WORD_W-1:0]   o_word,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_health_fail
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [N_BLOCKS-1:0] sync_p [SYNC_STAGES];
    logic [N_BLOCKS-1:0] sync_q;
    logic [DIV_W-1:0]    samp_cnt;
    logic                active;
    logic                strobe;
    logic                s;
    logic [REP_W-1:0]    rep_cnt;
    logic [REP_W-1:0]    rep_nxt;
    logic                prev_s;
    logic                fail_set;
    logic                emit;
    logic                emit_bit;
    logic [WORD_W-1:0]   shift;
    logic [CNT_W-1:0]    bit_cnt;
    logic                take;
    logic                out_free;
    logic                word_full;

    // Stage: metastability synchroniser per raw latch bit
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
        end else begin
            sync_p[0] <= i_block_Qs;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
        end
    end

    assign sync_q = sync_p[SYNC_STAGES-1];
    assign active = i_enb & ~o_health_fail;
    assign strobe = active && (samp_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign s      = ^sync_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)                samp_cnt <= '0;
        else if (!active || strobe) samp_cnt <= '0;
        else                        samp_cnt <= samp_cnt + 1'b1;
    end

    // Stage: repetition-count health test on the raw folded samples
    always_comb begin
        rep_nxt = rep_cnt;
        if (!i_enb) begin
            rep_nxt = '0;
        end else if (strobe) begin
            if (rep_cnt != '0 && s == prev_s) rep_nxt = rep_cnt + 1'b1;
            else                              rep_nxt = REP_W'(1);
        end
    end

    assign fail_set = strobe && (rep_nxt == REP_W'(REP_LIMIT));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rep_cnt       <= '0;
            prev_s        <= 1'b0;
            o_health_fail <= 1'b0;
            o_src_enb     <= 1'b0;
        end else begin
            rep_cnt <= rep_nxt;
            if (strobe)   prev_s        <= s;
            if (fail_set) o_health_fail <= 1'b1;
            o_src_enb <= i_enb & ~(o_health_fail | fail_set);
        end
    end

    // Stage: optional von Neumann debiaser
`ifdef AUXRAN_VN_DEBIAS_EN
    typedef enum logic {EMPTY, HAVE_FIRST} vn_state_t;
    vn_state_t vn_state;
    vn_state_t vn_next;
    logic      first_bit;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            vn_state  <= EMPTY;
            first_bit <= 1'b0;
        end else begin
            vn_state <= vn_next;
            if (strobe && vn_state == EMPTY) first_bit <= s;
        end
    end

    // A pair (0,1) yields 0 and (1,0) yields 1, i.e. the first bit of an unequal pair.
    always_comb begin
        vn_next  = vn_state;
        emit     = 1'b0;
        emit_bit = first_bit;
        if (!active || fail_set) begin
            vn_next = EMPTY;
        end else if (strobe) begin
            if (vn_state == EMPTY) begin
                vn_next = HAVE_FIRST;
            end else begin
                vn_next = EMPTY;
                emit    = (first_bit != s);
            end
        end
    end
`else
    assign emit     = strobe;
    assign emit_bit = s;
`endif

    // Stage: word shifter and valid/ready output register
    assign take      = o_valid & i_ready;
    assign out_free  = ~o_valid | take;
    assign word_full = (bit_cnt == CNT_W'(WORD_W));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            shift   <= '0;
            bit_cnt <= '0;
            o_word  <= '0;
            o_valid <= 1'b0;
        end else if (o_health_fail || fail_set) begin
            shift   <= '0;
            bit_cnt <= '0;
            o_valid <= 1'b0;
        end else begin
            if (word_full && out_free) begin
                o_word  <= shift;
                o_valid <= 1'b1;
            end else if (take) begin
                o_valid <= 1'b0;
            end

            // A bit emitted in the cycle the full word moves out starts the next word.
            if (!i_enb) begin
                shift   <= '0;
                bit_cnt <= '0;
            end else if (word_full) begin
                if (out_free) begin
                    if (emit) shift <= {shift[WORD_W-2:0], emit_bit};
                    bit_cnt <= emit ? CNT_W'(1) : '0;
                end
            end else if (emit) begin
                shift   <= {shift[WORD_W-2:0], emit_bit};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule
